// File: rtl/sram_sqi_arbiter.sv
// rtl/sram_sqi_arbiter.sv - 23LC1024 SQI sequencer shared by a video burst reader and a host port
// Video requests win ties; every transaction runs to completion before the next grant.
module sram_sqi_arbiter #(
   parameter int BURST_BYTES = 4,
   parameter int ADDR_W      = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [7:0]        vid_data,
   output logic              vid_valid,
   output logic              vid_done,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              host_ack,
   output logic              ready,
   output logic              sram_cs_n,
   output logic              sram_sck,
   output logic              sram_sio_oe,
   output logic [3:0]        sram_sio_o,
   input  logic [3:0]        sram_sio_i
);

   typedef enum logic [3:0] {
      INIT_CS, INIT_EQIO, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP
   } state_t;

   localparam logic [7:0] EQIO_CMD = 8'h38;
   localparam logic [5:0] VID_LAST = 6'(2 * BURST_BYTES - 1);

   state_t            state, state_d;
   logic              ph, ph_d;
   logic [5:0]        cnt, cnt_d, last_cnt;
   logic              grant_vid, grant_host;
   logic              cur_vid, cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        cur_wdata;
   logic [7:0]        cmd_byte;
   logic [7:0]        eqio_sh;
   logic [23:0]       addr_sh;
   logic [3:0]        rd_hi;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT_CS;
         ph    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         ph    <= ph_d;
         cnt   <= cnt_d;
      end
   end

   // ph is the SCK phase (0 = L, 1 = H); every state advances only at the end of phase H.
   always_comb begin
      grant_vid  = (state == IDLE) && vid_req;
      grant_host = (state == IDLE) && !vid_req && host_req;
      case (state)
         INIT_EQIO: last_cnt = 6'd7;
         CMD:       last_cnt = 6'd1;
         ADDR:      last_cnt = 6'd5;
         DUMMY:     last_cnt = 6'd1;
         RDATA:     last_cnt = cur_vid ? VID_LAST : 6'd1;
         WDATA:     last_cnt = 6'd1;
         default:   last_cnt = 6'd0;
      endcase
      state_d = state;
      ph_d    = ~ph;
      cnt_d   = cnt;
      if (state == IDLE) begin
         ph_d  = 1'b0;
         cnt_d = '0;
         if (grant_vid || grant_host)
            state_d = CMD;
      end else if (ph) begin
         if (cnt == last_cnt) begin
            cnt_d = '0;
            case (state)
               INIT_CS:   state_d = INIT_EQIO;
               INIT_EQIO: state_d = GAP;
               CMD:       state_d = ADDR;
               ADDR:      state_d = cur_we ? WDATA : DUMMY;
               DUMMY:     state_d = RDATA;
               RDATA:     state_d = GAP;
               WDATA:     state_d = GAP;
               GAP:       state_d = IDLE;
               default:   state_d = INIT_CS;
            endcase
         end else begin
            cnt_d = cnt + 6'd1;
         end
      end
   end

   assign cmd_byte = cur_we ? 8'h02 : 8'h03;
   assign eqio_sh  = EQIO_CMD << cnt[2:0];
   assign addr_sh  = 24'(cur_addr) << {cnt[2:0], 2'b00};

   always_comb begin
      sram_cs_n   = 1'b1;
      sram_sio_oe = 1'b0;
      sram_sio_o  = 4'h0;
      case (state)
         INIT_EQIO: begin
            sram_cs_n   = 1'b0;
            sram_sio_oe = 1'b1;
            sram_sio_o  = {3'b000, eqio_sh[7]};
         end
         CMD: begin
            sram_cs_n   = 1'b0;
            sram_sio_oe = 1'b1;
            sram_sio_o  = cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
         end
         ADDR: begin
            sram_cs_n   = 1'b0;
            sram_sio_oe = 1'b1;
            sram_sio_o  = addr_sh[23:20];
         end
         WDATA: begin
            sram_cs_n   = 1'b0;
            sram_sio_oe = 1'b1;
            sram_sio_o  = cnt[0] ? cur_wdata[3:0] : cur_wdata[7:4];
         end
         DUMMY, RDATA: sram_cs_n = 1'b0;
         default: ;
      endcase
   end

   assign sram_sck = ph & ~sram_cs_n;
   assign vid_ack  = grant_vid;
   assign ready    = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_vid    <= 1'b0;
         cur_we     <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         rd_hi      <= '0;
         vid_data   <= '0;
         vid_valid  <= 1'b0;
         vid_done   <= 1'b0;
         host_rdata <= '0;
         host_ack   <= 1'b0;
      end else begin
         vid_valid <= 1'b0;
         vid_done  <= 1'b0;
         host_ack  <= 1'b0;
         if (grant_vid) begin
            cur_vid  <= 1'b1;
            cur_we   <= 1'b0;
            cur_addr <= vid_addr;
         end else if (grant_host) begin
            cur_vid   <= 1'b0;
            cur_we    <= host_we;
            cur_addr  <= host_addr;
            cur_wdata <= host_wdata;
         end
         // Nibbles are captured at the end of phase H; odd nibble completes a byte.
         if (state == RDATA && ph) begin
            if (!cnt[0]) begin
               rd_hi <= sram_sio_i;
            end else if (cur_vid) begin
               vid_data  <= {rd_hi, sram_sio_i};
               vid_valid <= 1'b1;
               vid_done  <= (cnt == last_cnt);
            end else begin
               host_rdata <= {rd_hi, sram_sio_i};
               host_ack   <= 1'b1;
            end
         end
         if (state == WDATA && ph && cnt == last_cnt)
            host_ack <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_sqi_arbiter.sv
// tb/tb_sram_sqi_arbiter.sv - directed bench for sram_sqi_arbiter with a behavioural 23LC1024
module tb_sram_sqi_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0;
   logic [16:0] vid_addr = '0;
   logic        vid_ack;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        vid_done;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [16:0] host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic [7:0]  host_rdata;
   logic        host_ack;
   logic        ready;
   logic        sram_cs_n;
   logic        sram_sck;
   logic        sram_sio_oe;
   logic [3:0]  sram_sio_o;
   logic [3:0]  sram_sio_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_sqi_arbiter #(.BURST_BYTES(4), .ADDR_W(17)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_data(vid_data), .vid_valid(vid_valid), .vid_done(vid_done),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
      .ready(ready), .sram_cs_n(sram_cs_n), .sram_sck(sram_sck),
      .sram_sio_oe(sram_sio_oe), .sram_sio_o(sram_sio_o), .sram_sio_i(sram_sio_i)
   );

   // Serial SRAM model: powers up in SPI mode, EQIO switches to SQI.
   logic [7:0]  mem [0:131071];
   logic        sqi = 1'b0;
   int          nib = 0;
   logic [7:0]  spi_byte = '0;
   logic [7:0]  mcmd = '0;
   logic [23:0] maddr = '0;
   logic [7:0]  wb = '0;
   logic [3:0]  sio_drv = '0;

   assign sram_sio_i = sio_drv;

   always @(negedge sram_cs_n) begin
      nib = 0;
      spi_byte = '0;
      mcmd = '0;
   end

   always @(posedge sram_sck) begin
      if (!sram_cs_n) begin
         if (!sqi) begin
            spi_byte = {spi_byte[6:0], sram_sio_o[0]};
            nib++;
            if (nib == 8 && spi_byte == 8'h38) sqi = 1'b1;
         end else begin
            if (nib < 2) mcmd = {mcmd[3:0], sram_sio_o};
            else if (nib < 8) maddr = {maddr[19:0], sram_sio_o};
            else if (mcmd == 8'h02 && nib < 10) begin
               wb = {wb[3:0], sram_sio_o};
               if (nib == 9) mem[maddr[16:0]] = wb;
            end
            nib++;
         end
      end
   end

   always @(negedge sram_sck) begin
      if (!sram_cs_n && sqi && mcmd == 8'h03 && nib >= 10) begin
         if ((nib - 10) % 2 == 0) begin
            sio_drv = mem[maddr[16:0]][7:4];
         end else begin
            sio_drv = mem[maddr[16:0]][3:0];
            maddr[16:0] = maddr[16:0] + 17'd1;
         end
      end
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_init(input bit first);
      int low = 0;
      int rdy_at = -1;
      int acks = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (!sram_cs_n) low++;
         if (host_ack) acks++;
         if (ready && rdy_at < 0) rdy_at = n;
      end
      check_value("init_cs_low", low, 16);
      check_value("init_ready_clk", rdy_at, 20);
      check_value("init_no_ack", acks, 0);
      if (first) check_value("init_eqio_byte", {23'd0, sqi, spi_byte}, {23'd0, 1'b1, 8'h38});
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 200 && !ready; n++) @(negedge clk);
      check_value("wait_ready", ready, 1);
   endtask

   task automatic host_op(input logic we, input logic [16:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int low, output bit ok);
      low = 0;
      ok = 1'b0;
      rd = '0;
      wait_ready();
      @(negedge clk);
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!sram_cs_n) low++;
         if (host_ack) begin
            rd = host_rdata;
            ok = 1'b1;
            break;
         end
      end
      host_req = 1'b0;
   endtask

   logic [7:0] vbytes[$];
   int         vdone_idx;

   task automatic vid_burst(input logic [16:0] a, output int low, output bit ok);
      low = 0;
      ok = 1'b0;
      vbytes.delete();
      vdone_idx = -1;
      wait_ready();
      @(negedge clk);
      vid_req = 1'b1; vid_addr = a;
      #1;
      check_value("vid_ack_grant", vid_ack, 1);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         vid_req = 1'b0;
         if (!sram_cs_n) low++;
         if (vid_valid) vbytes.push_back(vid_data);
         if (vid_done) begin
            vdone_idx = vbytes.size();
            ok = 1'b1;
            break;
         end
      end
      vid_req = 1'b0;
   endtask

   logic [7:0] rd;
   int         low;
   bit         ok;
   logic [7:0] exp_b [4];

   initial begin
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_value("rst_cs_n", sram_cs_n, 1);
      check_value("rst_sck", sram_sck, 0);
      check_value("rst_oe", sram_sio_oe, 0);
      check_value("rst_sio_o", sram_sio_o, 0);
      check_value("rst_pulses", {vid_valid, vid_done, host_ack, ready}, 0);
      check_value("rst_data", {vid_data, host_rdata}, 0);
      run_init(1'b1);

      host_op(1'b1, 17'h00123, 8'hA5, rd, low, ok);
      check_value("wr_ack", ok, 1);
      check_value("wr_cs_low", low, 20);
      check_value("wr_mem", mem[17'h00123], 8'hA5);
      check_value("wr_rdata_kept", rd, 8'h00);
      host_op(1'b0, 17'h00123, 8'h00, rd, low, ok);
      check_value("rd_ack", ok, 1);
      check_value("rd_data", rd, 8'hA5);
      check_value("rd_cs_low", low, 24);

      mem[17'h100] = 8'h11; mem[17'h101] = 8'h22; mem[17'h102] = 8'h33; mem[17'h103] = 8'h44;
      vid_burst(17'h00100, low, ok);
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      check_value("burst_done", ok, 1);
      check_value("burst_count", vbytes.size(), 4);
      for (int i = 0; i < 4 && i < vbytes.size(); i++) check_value($sformatf("burst_b%0d", i), vbytes[i], exp_b[i]);
      check_value("burst_done_idx", vdone_idx, 4);
      check_value("burst_cs_low", low, 36);

      begin
         int prev_cs, rise, fall, grant, vcnt;
         bit hdone;
         prev_cs = 1; rise = -1; fall = -1; grant = -1; vcnt = 0; hdone = 1'b0;
         wait_ready();
         @(negedge clk);
         vid_req = 1'b1; vid_addr = 17'h00100;
         host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00200; host_wdata = 8'h5C;
         #1;
         check_value("sim_vid_ack", vid_ack, 1);
         for (int n = 1; n < 400; n++) begin
            @(negedge clk);
            vid_req = 1'b0;
            if (rise < 0 && prev_cs == 0 && sram_cs_n == 1'b1) rise = n;
            else if (rise >= 0 && fall < 0 && prev_cs == 1 && sram_cs_n == 1'b0) fall = n;
            if (rise >= 0 && grant < 0 && ready) grant = n;
            if (vid_valid) vcnt++;
            prev_cs = int'(sram_cs_n);
            if (host_ack) begin
               hdone = 1'b1;
               break;
            end
         end
         host_req = 1'b0;
         check_value("sim_host_ack", hdone, 1);
         check_value("sim_vid_bytes", vcnt, 4);
         check_value("sim_grant_gap", grant - rise, 2);
         check_value("sim_cs_gap", fall - rise, 3);
         check_value("sim_host_mem", mem[17'h00200], 8'h5C);
      end

      mem[17'h1FFFE] = 8'hE1; mem[17'h1FFFF] = 8'hE2; mem[17'h00000] = 8'hE3; mem[17'h00001] = 8'hE4;
      vid_burst(17'h1FFFE, low, ok);
      exp_b[0] = 8'hE1; exp_b[1] = 8'hE2; exp_b[2] = 8'hE3; exp_b[3] = 8'hE4;
      check_value("wrap_done", ok, 1);
      check_value("wrap_count", vbytes.size(), 4);
      for (int i = 0; i < 4 && i < vbytes.size(); i++) check_value($sformatf("wrap_b%0d", i), vbytes[i], exp_b[i]);

      mem[17'h00456] = 8'h5A;
      wait_ready();
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00456; host_wdata = 8'hC3;
      repeat (7) @(negedge clk);
      check_value("abort_in_addr", {sram_cs_n, sram_sio_oe}, 2'b01);
      reset = 1'b1;
      @(negedge clk);
      host_req = 1'b0;
      check_value("abort_cs_n", sram_cs_n, 1);
      check_value("abort_oe", sram_sio_oe, 0);
      check_value("abort_no_ack", host_ack, 0);
      run_init(1'b0);
      check_value("abort_mem_kept", mem[17'h00456], 8'h5A);
      host_op(1'b0, 17'h00456, 8'h00, rd, low, ok);
      check_value("abort_readback_ack", ok, 1);
      check_value("abort_readback", rd, 8'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
